// File: rtl/ascon_permutation_engine.sv
// ASCON p^a permutation engine: UNROLL chained rounds per clock behind a start/done
// handshake, with a 1..12 round count selected at accept time.
package ascon_pkg;
    // x0 occupies [319:256] down to x4 in [63:0]
    typedef logic [319:0] type_state;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        logic [127:0] w;
        w = {x, x} >> n;
        return w[63:0];
    endfunction
endpackage

module ascon_const_add
    import ascon_pkg::*;
(
    input  logic [3:0] i_idx,
    input  type_state  i_state,
    output type_state  o_state
);
    logic [63:0] w_rc;

    always_comb begin
        w_rc    = {56'h0, 4'hF - i_idx, i_idx};
        o_state = i_state;
        o_state[191:128] = i_state[191:128] ^ w_rc;
    end
endmodule

module ascon_sbox_layer
    import ascon_pkg::*;
(
    input  type_state i_state,
    output type_state o_state
);
    logic [63:0] w_a0, w_a1, w_a2, w_a3, w_a4;
    logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;
    logic [63:0] w_b0, w_b1, w_b2, w_b3, w_b4;

    // Bitsliced 5-bit S-box applied to all 64 columns at once
    assign w_a0 = i_state[319:256] ^ i_state[63:0];
    assign w_a1 = i_state[255:192];
    assign w_a2 = i_state[191:128] ^ i_state[255:192];
    assign w_a3 = i_state[127:64];
    assign w_a4 = i_state[63:0] ^ i_state[127:64];

    assign w_t0 = ~w_a0 & w_a1;
    assign w_t1 = ~w_a1 & w_a2;
    assign w_t2 = ~w_a2 & w_a3;
    assign w_t3 = ~w_a3 & w_a4;
    assign w_t4 = ~w_a4 & w_a0;

    assign w_b0 = w_a0 ^ w_t1;
    assign w_b1 = w_a1 ^ w_t2;
    assign w_b2 = w_a2 ^ w_t3;
    assign w_b3 = w_a3 ^ w_t4;
    assign w_b4 = w_a4 ^ w_t0;

    assign o_state = {w_b0 ^ w_b4, w_b1 ^ w_b0, ~w_b2, w_b3 ^ w_b2, w_b4};
endmodule

module ascon_linear_layer
    import ascon_pkg::*;
(
    input  type_state i_state,
    output type_state o_state
);
    logic [63:0] w_x0, w_x1, w_x2, w_x3, w_x4;

    assign w_x0 = i_state[319:256];
    assign w_x1 = i_state[255:192];
    assign w_x2 = i_state[191:128];
    assign w_x3 = i_state[127:64];
    assign w_x4 = i_state[63:0];

    assign o_state = {
        w_x0 ^ ror64(w_x0, 19) ^ ror64(w_x0, 28),
        w_x1 ^ ror64(w_x1, 61) ^ ror64(w_x1, 39),
        w_x2 ^ ror64(w_x2,  1) ^ ror64(w_x2,  6),
        w_x3 ^ ror64(w_x3, 10) ^ ror64(w_x3, 17),
        w_x4 ^ ror64(w_x4,  7) ^ ror64(w_x4, 41)
    };
endmodule

module ascon_round_stage
    import ascon_pkg::*;
(
    input  logic [3:0] i_idx,
    input  logic       i_en,
    input  type_state  i_state,
    output type_state  o_state
);
    type_state w_pc, w_ps, w_pl;

    ascon_const_add    u_pc (.i_idx(i_idx), .i_state(i_state), .o_state(w_pc));
    ascon_sbox_layer   u_ps (.i_state(w_pc), .o_state(w_ps));
    ascon_linear_layer u_pl (.i_state(w_ps), .o_state(w_pl));

    // Rounds past index 11 fall off the end of p^a and must not touch the state
    assign o_state = i_en ? w_pl : i_state;
endmodule

module ascon_permutation_engine
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic [3:0] rounds_i,
    input  type_state  state_i,
    output logic       ready_o,
    output logic       done_o,
    output logic       busy_o,
    output logic [3:0] round_o,
    output type_state  state_o
);
    if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
        $error("ascon_permutation_engine: UNROLL must be in 1..4");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

    fsm_t        r_fsm, w_fsm_nxt;
    type_state   r_state;
    logic [3:0]  r_round;
    logic        w_load, w_step;
    logic [3:0]  w_na, w_round_init, w_round_nxt;
    logic [4:0]  w_rsum;
    type_state   w_chain [UNROLL+1];

    assign w_na         = (rounds_i == 4'd0 || rounds_i > 4'd12) ? 4'd12 : rounds_i;
    assign w_round_init = 4'd12 - w_na;

    // Saturating advance; r_round never exceeds 12
    assign w_rsum      = {1'b0, r_round} + 5'(UNROLL);
    assign w_round_nxt = (w_rsum >= 5'd12) ? 4'd12 : w_rsum[3:0];

    assign w_chain[0] = r_state;

    for (genvar k = 0; k < UNROLL; k++) begin : g_stage
        logic [4:0] w_idx;
        assign w_idx = {1'b0, r_round} + 5'(k);
        ascon_round_stage u_round (
            .i_idx   (w_idx[3:0]),
            .i_en    (w_idx <= 5'd11),
            .i_state (w_chain[k]),
            .o_state (w_chain[k+1])
        );
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) r_fsm <= S_IDLE;
        else           r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        w_load    = 1'b0;
        w_step    = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (start_i) begin
                    w_load    = 1'b1;
                    w_fsm_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_round_nxt == 4'd12) w_fsm_nxt = S_DONE;
            end
            S_DONE: begin
                if (start_i) begin
                    w_load    = 1'b1;
                    w_fsm_nxt = S_RUN;
                end else begin
                    w_fsm_nxt = S_IDLE;
                end
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state <= '0;
            r_round <= 4'd0;
        end else if (w_load) begin
            r_state <= state_i;
            r_round <= w_round_init;
        end else if (w_step) begin
            r_state <= w_chain[UNROLL];
            r_round <= w_round_nxt;
        end
    end

    assign ready_o = (r_fsm == S_IDLE) || (r_fsm == S_DONE);
    assign busy_o  = (r_fsm == S_RUN);
    assign done_o  = (r_fsm == S_DONE);
    assign round_o = r_round;
    assign state_o = r_state;
endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Bench for ascon_permutation_engine: one instance per UNROLL value, checked against
// a column-wise S-box-table reference model of p^a.
module tb_ascon_permutation_engine;
    import ascon_pkg::*;

    logic       clk  = 1'b0;
    logic       rstb = 1'b1;
    logic       start_v [4];
    logic [3:0] rounds;
    type_state  st_in;
    logic       ready_v [4];
    logic       done_v  [4];
    logic       busy_v  [4];
    logic [3:0] round_v [4];
    type_state  so_v    [4];

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ascon_permutation_engine #(.UNROLL(g + 1)) u_dut (
            .clock_i  (clk),
            .resetb_i (rstb),
            .start_i  (start_v[g]),
            .rounds_i (rounds),
            .state_i  (st_in),
            .ready_o  (ready_v[g]),
            .done_o   (done_v[g]),
            .busy_o   (busy_v[g]),
            .round_o  (round_v[g]),
            .state_o  (so_v[g])
        );
    end

    int sbox_t [32] = '{4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
                        30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23};
    int rot_a [5] = '{19, 61, 1, 10, 7};
    int rot_b [5] = '{28, 39, 6, 17, 41};

    function automatic type_state model_perm(input type_state s, input logic [3:0] r);
        logic [63:0] x [5];
        logic [63:0] y;
        int na, col, o;
        na = (r == 4'd0 || r > 4'd12) ? 12 : int'(r);
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int rr = 12 - na; rr < 12; rr++) begin
            x[2] = x[2] ^ 64'((15 - rr) * 16 + rr);
            for (int b = 0; b < 64; b++) begin
                col = 16*int'(x[0][b]) + 8*int'(x[1][b]) + 4*int'(x[2][b])
                    + 2*int'(x[3][b]) + int'(x[4][b]);
                o = sbox_t[col];
                x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2];
                x[3][b] = o[1]; x[4][b] = o[0];
            end
            for (int i = 0; i < 5; i++) begin
                y = x[i];
                for (int b = 0; b < 64; b++)
                    x[i][b] = y[b] ^ y[(b + rot_a[i]) % 64] ^ y[(b + rot_b[i]) % 64];
            end
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic type_state rnd_st();
        type_state s;
        for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    typedef struct {
        int         u;
        logic [3:0] rounds;
        int         exp_cyc;
    } vec_t;

    function automatic vec_t mkv(input int u, input logic [3:0] r, input int c);
        vec_t v;
        v.u = u; v.rounds = r; v.exp_cyc = c;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start_op(input int u, input logic [3:0] r, input type_state st);
        start_v[u] = 1'b1;
        rounds     = r;
        st_in      = st;
        @(posedge clk); #1;
        start_v[u] = 1'b0;
        chk("accept_busy", busy_v[u], 1);
        chk("accept_nodone", done_v[u], 0);
    endtask

    // Counts RUN edges until done; optionally pulses start with junk inputs at edge 'inj'
    task automatic wait_done(input int u, input int inj, output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk); cyc++; #1;
            if (done_v[u]) break;
            if (cyc == inj) begin
                start_v[u] = 1'b1;
                st_in      = ~st_in;
                rounds     = 4'd1;
            end else begin
                start_v[u] = 1'b0;
            end
        end
        start_v[u] = 1'b0;
    endtask

    task automatic run_op(input string tag, input int u, input logic [3:0] r,
                          input type_state st, input int exp_cyc, input int inj);
        type_state exp_s;
        int cyc;
        exp_s = model_perm(st, r);
        start_op(u, r, st);
        wait_done(u, inj, cyc);
        chk({tag, "_latency"}, cyc, exp_cyc);
        chk({tag, "_result"}, so_v[u], exp_s);
        chk({tag, "_round12"}, round_v[u], 12);
        chk({tag, "_ready_in_done"}, ready_v[u], 1);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done_v[u], 0);
        chk({tag, "_held"}, so_v[u], exp_s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t      vecs [$];
        type_state sa, sb;
        int        cyc;
        logic      seen;

        for (int u = 0; u < 4; u++) start_v[u] = 1'b0;
        rounds = 4'd0;
        st_in  = '0;
        #1 rstb = 1'b0;
        #2;
        for (int u = 0; u < 4; u++) begin
            chk($sformatf("reset_state_u%0d", u + 1), so_v[u], 0);
            chk($sformatf("reset_round_u%0d", u + 1), round_v[u], 0);
            chk($sformatf("reset_ready_u%0d", u + 1), ready_v[u], 1);
            chk($sformatf("reset_done_u%0d", u + 1), done_v[u], 0);
            chk($sformatf("reset_busy_u%0d", u + 1), busy_v[u], 0);
        end
        #4 rstb = 1'b1;

        run_op("p12_zero_u1", 0, 4'd12, '0, 12, 0);

        // {UNROLL, rounds_i, expected RUN edges}
        vecs.push_back(mkv(1, 4'd1, 1));  vecs.push_back(mkv(1, 4'd6, 6));
        vecs.push_back(mkv(1, 4'd8, 8));  vecs.push_back(mkv(1, 4'd12, 12));
        vecs.push_back(mkv(2, 4'd1, 1));  vecs.push_back(mkv(2, 4'd6, 3));
        vecs.push_back(mkv(2, 4'd8, 4));  vecs.push_back(mkv(2, 4'd12, 6));
        vecs.push_back(mkv(3, 4'd1, 1));  vecs.push_back(mkv(3, 4'd6, 2));
        vecs.push_back(mkv(3, 4'd8, 3));  vecs.push_back(mkv(3, 4'd12, 4));
        vecs.push_back(mkv(4, 4'd1, 1));  vecs.push_back(mkv(4, 4'd6, 2));
        vecs.push_back(mkv(4, 4'd8, 2));  vecs.push_back(mkv(4, 4'd12, 3));
        vecs.push_back(mkv(1, 4'd0, 12)); vecs.push_back(mkv(1, 4'hF, 12));
        vecs.push_back(mkv(3, 4'd0, 4));  vecs.push_back(mkv(4, 4'hF, 3));
        vecs.push_back(mkv(2, 4'd13, 6));

        foreach (vecs[i])
            run_op($sformatf("vec%0d_u%0d_r%0d", i, vecs[i].u, vecs[i].rounds),
                   vecs[i].u - 1, vecs[i].rounds, rnd_st(), vecs[i].exp_cyc, 0);

        // Back-to-back on UNROLL=2: second request presented during the DONE cycle
        sa = rnd_st();
        sb = rnd_st();
        start_op(1, 4'd6, sa);
        wait_done(1, 0, cyc);
        chk("b2b_first_latency", cyc, 3);
        chk("b2b_first_result", so_v[1], model_perm(sa, 4'd6));
        start_op(1, 4'd8, sb);
        wait_done(1, 0, cyc);
        chk("b2b_second_latency", cyc, 4);
        chk("b2b_second_result", so_v[1], model_perm(sb, 4'd8));
        @(posedge clk); #1;
        chk("b2b_done_pulse", done_v[1], 0);
        chk("b2b_idle_ready", ready_v[1], 1);

        // start_i mid-RUN with different inputs must be ignored
        run_op("ignore_midrun_u1", 0, 4'd12, rnd_st(), 12, 3);
        run_op("ignore_midrun_u4", 3, 4'd12, rnd_st(), 3, 1);

        // Asynchronous reset pulse during RUN aborts the operation
        start_op(2, 4'd12, rnd_st());
        @(posedge clk); #1;
        rstb = 1'b0;
        #1;
        chk("abort_state", so_v[2], 0);
        chk("abort_round", round_v[2], 0);
        chk("abort_busy", busy_v[2], 0);
        chk("abort_ready", ready_v[2], 1);
        chk("abort_done", done_v[2], 0);
        rstb = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done_v[2]) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_state_kept", so_v[2], 0);
        run_op("post_abort_u3", 2, 4'd8, rnd_st(), 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
